rggen_apb_requester: RTL and testbench
======================================

// Module: rggen_apb_requester
// PURPOSE
//  APB4 requester (initiator): turns one-at-a-time register commands into APB SETUP/ACCESS transfers
//  toward an APB-slave register block. Returns read data and a 2-bit status.
//  Sits between a CPU/test sequencer command port and the i_p* inputs of a generated register block.
//  A per-transfer timeout guards against a hung completer.
// PARAMETERS
//  ADDRESS_WIDTH   16      width of o_paddr / i_address
//  DATA_WIDTH      32      width of APB data; must be 8, 16, 32 or 64
//  PPROT_VALUE     3'b000  constant driven on o_pprot
//  TIMEOUT_CYCLES  256     max ACCESS cycles awaiting i_pready; 0 disables the timeout
// PORTS
//  clk               in   1                clock
//  rst_n             in   1                asynchronous active-low reset
//  i_command_valid   in   1                command request
//  o_command_ready   out  1                command accepted when valid&&ready
//  i_write           in   1                1=write, 0=read
//  i_address         in   ADDRESS_WIDTH    byte address
//  i_strobe          in   DATA_WIDTH/8     byte enables (writes only)
//  i_write_data      in   DATA_WIDTH       write data
//  o_response_valid  out  1                response available
//  i_response_ready  in   1                response consumed when valid&&ready
//  o_read_data       out  DATA_WIDTH       read data (0 for writes/errors)
//  o_status          out  2                00 OKAY, 10 SLVERR, 11 timeout
//  o_paddr/o_pprot/o_psel/o_penable/o_pwrite/o_pwdata/o_pstrb  out  APB4 request signals
//  i_pready/i_prdata/i_pslverr                                 in   APB4 completion signals
// BEHAVIOUR
//  - FSM states: IDLE, SETUP, ACCESS, RESPONSE. Reset -> IDLE.
//  - Reset values: all outputs 0, except o_command_ready = 1 (IDLE). Includes o_psel, o_penable,
//    o_paddr, o_pwdata, o_pstrb, o_response_valid, o_read_data and o_status.
//  - IDLE: o_command_ready=1. On valid&&ready, the command goes to SETUP next cycle.
//    Registered and held stable until return to IDLE: address, write, strobe and data.
//    Strobe is forced to 0 for reads.
//  - SETUP (exactly 1 cycle): o_psel=1, o_penable=0. Next state is always ACCESS.
//  - ACCESS: o_psel=1, o_penable=1. The wait counter increments each cycle i_pready=0.
//    - i_pready=1: capture status (i_pslverr ? 10 : 00) and data.
//      Data = read && !pslverr ? i_prdata : 0. Go to RESPONSE.
//    - Counter reaches TIMEOUT_CYCLES-1 with i_pready=0 (TIMEOUT_CYCLES!=0): status=11, data=0, go to RESPONSE.
//      The completer is considered abandoned.
//    - i_pready has priority over timeout in the same cycle.
//  - RESPONSE: o_psel=o_penable=0 and o_response_valid=1.
//    o_read_data and o_status are held until i_response_ready=1, then go to IDLE.
//    Minimum turnaround: a new command is accepted only in IDLE, so there is >=1 idle APB cycle between transfers.
//  - Latency (zero-wait completer, immediate response_ready):
//    accept@T, SETUP@T+1, ACCESS@T+2, response_valid@T+3, ready again@T+4.
//  - o_command_ready=0 outside IDLE; commands presented then are not consumed.
//  - i_prdata and i_pslverr are sampled only in ACCESS with i_pready=1; otherwise ignored.
//  - Wait counter: width clog2(TIMEOUT_CYCLES+1), cleared on entry to SETUP, no wrap (saturates).
//  - Async reset mid-transfer: the APB signals drop to 0 immediately and any pending response is discarded.
//  - o_pprot=PPROT_VALUE whenever o_psel=1, 0 otherwise.
//  - o_pwrite, o_paddr, o_pwdata and o_pstrb stay constant from SETUP through the last ACCESS cycle (APB4 stability).
// TESTING
//  1 Write 0x0000_1234 to addr 0x0004, strobe 0xF, pready=1 at first ACCESS
//    -> psel@T+1, penable@T+2, pwdata=0x1234, status 00, rdata 0.
//  2 Read addr 0x0008 with 3 wait states, prdata=0xDEAD_BEEF
//    -> penable held 4 cycles, paddr stable, o_read_data=0xDEADBEEF, status 00, o_pstrb=0.
//  3 Read with pready=1 and pslverr=1 -> status 10, o_read_data=0, psel drops next cycle.
//  4 TIMEOUT_CYCLES=4, pready held 0 -> ACCESS lasts exactly 4 cycles, then status 11, data 0, psel=0.
//    Then TIMEOUT_CYCLES=0 with 1000 wait cycles -> no timeout.
//  5 Response backpressure: i_response_ready=0 for 5 cycles
//    -> response_valid/data/status held, command_ready=0, no new APB transfer; a queued command is accepted only after handshake.
//  6 rst_n asserted during ACCESS -> psel/penable/response_valid=0 immediately, command_ready=1 after release.
//    The next write completes normally.

Source files
------------

// File: rtl/rggen_apb_requester_if.sv
// rggen_apb_requester_if: APB4 request/completion signal bundle between requester and completer
interface rggen_apb_requester_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [2:0]                pprot;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_apb_requester.sv
// rggen_apb_requester: APB4 requester turning single register commands into SETUP/ACCESS transfers
module rggen_apb_requester #(
    parameter int         ADDRESS_WIDTH  = 16,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [2:0] PPROT_VALUE    = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_command_valid,
    output logic                      o_command_ready,
    input  logic                      i_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH/8-1:0]   i_strobe,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic [1:0]                o_status,
    rggen_apb_requester_if.master     apb
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      write_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [CW-1:0]             cnt_q;
    logic                      rvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                status_q;
    logic                      timeout_hit;

    // A waiting completer is abandoned once the last allowed ACCESS cycle passes without pready
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Transfer sequencer; every bus and handshake output is a register of this FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            status_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_command_valid) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        psel_q  <= 1'b1;
                        write_q <= i_write;
                        addr_q  <= i_address;
                        strb_q  <= i_write ? i_strobe : '0;
                        wdata_q <= i_write_data;
                        cnt_q   <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (apb.pready || timeout_hit) begin
                        state_q   <= RESPONSE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        status_q  <= apb.pready ? {apb.pslverr, 1'b0} : 2'b11;
                        rdata_q   <= (apb.pready && !write_q && !apb.pslverr) ? apb.prdata : '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESPONSE: begin
                    if (i_response_ready) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_command_ready  = ready_q;
    assign o_response_valid = rvalid_q;
    assign o_read_data      = rdata_q;
    assign o_status         = status_q;
    assign apb.paddr        = addr_q;
    assign apb.pprot        = psel_q ? PPROT_VALUE : 3'b000;
    assign apb.psel         = psel_q;
    assign apb.penable      = penable_q;
    assign apb.pwrite       = write_q;
    assign apb.pwdata       = wdata_q;
    assign apb.pstrb        = strb_q;
endmodule

// File: tb/tb_rggen_apb_requester.sv
// tb_rggen_apb_requester: scoreboard bench for the APB4 requester (timeout 4 and timeout disabled)
module tb_rggen_apb_requester;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, write, rsp_valid, rsp_ready;
    logic [AW-1:0] addr;
    logic [3:0]    strb;
    logic [31:0]   wdata, rdata;
    logic [1:0]    status;

    logic          cmd_valid1, cmd_ready1, write1, rsp_valid1, rsp_ready1;
    logic [AW-1:0] addr1;
    logic [3:0]    strb1;
    logic [31:0]   wdata1, rdata1;
    logic [1:0]    status1;

    rggen_apb_requester_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb0 ();
    rggen_apb_requester_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb1 ();

    rggen_apb_requester #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PPROT_VALUE(3'b101), .TIMEOUT_CYCLES(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_command_valid(cmd_valid), .o_command_ready(cmd_ready),
        .i_write(write), .i_address(addr), .i_strobe(strb), .i_write_data(wdata),
        .o_response_valid(rsp_valid), .i_response_ready(rsp_ready),
        .o_read_data(rdata), .o_status(status), .apb(apb0)
    );

    rggen_apb_requester #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PPROT_VALUE(3'b000), .TIMEOUT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_command_valid(cmd_valid1), .o_command_ready(cmd_ready1),
        .i_write(write1), .i_address(addr1), .i_strobe(strb1), .i_write_data(wdata1),
        .o_response_valid(rsp_valid1), .i_response_ready(rsp_ready1),
        .o_read_data(rdata1), .o_status(status1), .apb(apb1)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Response monitors: pop the expected response on every valid&&ready handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp0_unexpected: got data 0x%0h status %0b, want no response", rdata, status);
            end else begin
                e0 = q0.pop_front();
                chk("rsp0_data", rdata, e0.rd);
                chk("rsp0_status", status, e0.st);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid1 && rsp_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp1_unexpected: got data 0x%0h status %0b, want no response", rdata1, status1);
            end else begin
                e1 = q1.pop_front();
                chk("rsp1_data", rdata1, e1.rd);
                chk("rsp1_status", status1, e1.st);
            end
        end
    end

    // Issue one command on dut0 from IDLE and follow it up to the first RESPONSE cycle
    task automatic xfer(input logic w, input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int waits, input int acc, input logic err, input logic [31:0] rd,
                        input logic [1:0] est, input logic [31:0] erd);
        cmd_valid = 1'b1;
        write = w;
        addr = a;
        strb = s;
        wdata = d;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_psel", apb0.psel, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        write = ~w;
        addr = ~a;
        strb = ~s;
        wdata = ~d;
        q0.push_back(exp_t'{st: est, rd: erd});
        apb0.pready = 1'b0;
        apb0.pslverr = err;
        apb0.prdata = rd;
        @(negedge clk);
        chk("setup_psel", apb0.psel, 1);
        chk("setup_penable", apb0.penable, 0);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_paddr", apb0.paddr, a);
        chk("setup_pwrite", apb0.pwrite, w);
        chk("setup_pstrb", apb0.pstrb, w ? s : 4'h0);
        chk("setup_pprot", apb0.pprot, 3'b101);
        if (w) chk("setup_pwdata", apb0.pwdata, d);
        for (int i = 0; i < acc; i++) begin
            @(posedge clk); #1;
            apb0.pready = (i == waits);
            @(negedge clk);
            chk("access_psel", apb0.psel, 1);
            chk("access_penable", apb0.penable, 1);
            chk("access_paddr", apb0.paddr, a);
            chk("access_pstrb", apb0.pstrb, w ? s : 4'h0);
            chk("access_rsp_valid", rsp_valid, 0);
            if (w) chk("access_pwdata", apb0.pwdata, d);
        end
        @(posedge clk); #1;
        apb0.pready = 1'b0;
        apb0.pslverr = 1'b1;
        apb0.prdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("resp_psel", apb0.psel, 0);
        chk("resp_penable", apb0.penable, 0);
        chk("resp_pprot", apb0.pprot, 3'b000);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_cmd_ready", cmd_ready, 0);
    endtask

    task automatic run(input logic w, input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                       input int waits, input int acc, input logic err, input logic [31:0] rd,
                       input logic [1:0] est, input logic [31:0] erd);
        xfer(w, a, s, d, waits, acc, err, rd, est, erd);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        int dropped;
        cmd_valid = 0; write = 0; addr = '0; strb = '0; wdata = '0; rsp_ready = 1;
        cmd_valid1 = 0; write1 = 0; addr1 = '0; strb1 = '0; wdata1 = '0; rsp_ready1 = 1;
        apb0.pready = 0; apb0.prdata = '0; apb0.pslverr = 0;
        apb1.pready = 0; apb1.prdata = '0; apb1.pslverr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", apb0.psel, 0);
        chk("rst_penable", apb0.penable, 0);
        chk("rst_paddr", apb0.paddr, 0);
        chk("rst_pwdata", apb0.pwdata, 0);
        chk("rst_pstrb", apb0.pstrb, 0);
        chk("rst_pwrite", apb0.pwrite, 0);
        chk("rst_pprot", apb0.pprot, 0);
        chk("rst_read_data", rdata, 0);
        chk("rst_status", status, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait write
        run(1, 16'h0004, 4'hF, 32'h0000_1234, 0, 1, 0, 32'h1111_2222, 2'b00, 32'h0);
        // read with 3 wait states; pready on the last cycle before timeout wins
        run(0, 16'h0008, 4'hF, 32'h0, 3, 4, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);
        // read error
        run(0, 16'h000C, 4'h0, 32'h0, 0, 1, 1, 32'h1234_5678, 2'b10, 32'h0);
        // write error with partial strobe
        run(1, 16'h0010, 4'h3, 32'hA5A5_5A5A, 1, 2, 1, 32'h0, 2'b10, 32'h0);
        // completer never answers: timeout after exactly 4 ACCESS cycles
        run(0, 16'h0014, 4'h0, 32'h0, 99, 4, 0, 32'h7777_7777, 2'b11, 32'h0);

        // response backpressure with a queued command
        rsp_ready = 1'b0;
        xfer(0, 16'h0020, 4'h0, 32'h0, 0, 1, 0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            write = 1'b1;
            addr = 16'h0030;
            strb = 4'hF;
            wdata = 32'h0BAD_CAFE;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rdata, 32'hCAFE_F00D);
            chk("hold_status", status, 2'b00);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", apb0.psel, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        run(1, 16'h0030, 4'hF, 32'h0BAD_CAFE, 0, 1, 0, 32'h0, 2'b00, 32'h0);

        // async reset in the middle of ACCESS
        cmd_valid = 1'b1;
        write = 1'b0;
        addr = 16'h0040;
        strb = 4'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        apb0.pready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_penable", apb0.penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", apb0.psel, 0);
        chk("mid_rst_penable", apb0.penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1, 16'h0044, 4'hC, 32'h1357_9BDF, 0, 1, 0, 32'h0, 2'b00, 32'h0);

        // timeout disabled: 1000 wait cycles then completion
        cmd_valid1 = 1'b1;
        addr1 = 16'h0050;
        @(negedge clk);
        chk("nt_cmd_ready", cmd_ready1, 1);
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        q1.push_back(exp_t'{st: 2'b00, rd: 32'h55AA_1234});
        apb1.prdata = 32'h55AA_1234;
        @(negedge clk);
        chk("nt_setup_psel", apb1.psel, 1);
        dropped = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!(apb1.psel && apb1.penable) || rsp_valid1) dropped++;
        end
        chk("nt_access_held", dropped, 0);
        apb1.pready = 1'b1;
        @(posedge clk); #1;
        apb1.pready = 1'b0;
        @(negedge clk);
        chk("nt_rsp_valid", rsp_valid1, 1);
        chk("nt_psel", apb1.psel, 0);
        @(posedge clk); #1;
        @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
